axilm_wr_arb: RTL and testbench
===============================

# axilm_wr_arb

Round-robin arbiter that shares one AXI-Lite master write channel between `NUM_REQ` local requesters. It sits between the requesters and the write channel's local interface (`BUS_*`). It latches one requester's address, data and strobes, issues a single-cycle `BUS_ENA` to the write channel, and waits for the write-response completion strobe. It then returns the response to the granted requester with a one-cycle acknowledge.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `IDX_W`, default `$clog2(NUM_REQ)`: grant index width; derived, not overridden.

Ports:
- `ACLK` in 1: single clock; all logic on the rising edge.
- `ARESETn` in 1: reset, asynchronous, active-low.
- `REQ_ENA` in NUM_REQ: per-requester write request, level; held until the matching `REQ_ACK`.
- `REQ_WSTB` in 4*NUM_REQ: byte strobes; requester i uses `[4i+3:4i]`.
- `REQ_ADDR` in 32*NUM_REQ: write address; requester i uses `[32i+31:32i]`.
- `REQ_WDATA` in 32*NUM_REQ: write data; requester i uses `[32i+31:32i]`.
- `REQ_ACK` out NUM_REQ: one-hot, one-cycle completion pulse to the granted requester.
- `REQ_BRESP` out 2: response for the acked transfer; valid while `REQ_ACK` is non-zero, holds its value otherwise.
- `BUSY` out 1: high in every state except IDLE.
- `GRANT_IDX` out IDX_W: index of the current or last granted requester.
- `BUS_ENA` out 1: single-cycle write request to the write channel.
- `BUS_WSTB` out 4: strobes to the write channel.
- `BUS_ADDR` out 32: address to the write channel.
- `BUS_WDATA` out 32: data to the write channel.
- `BUS_DONE` in 1: one-cycle strobe from the write channel when its write response has been captured.
- `BUS_BRESP` in 2: write channel response; sampled only when `BUS_DONE=1`.

## Operation
- Reset values: every output is 0. Internal state: state=IDLE and priority pointer=0, so requester 0 has the highest priority after reset.
- States:
  - IDLE: if any `REQ_ENA` bit is set, pick a winner, register `GRANT_IDX` and latch its `WSTB`, `ADDR` and `WDATA` into the `BUS_*` registers.
    - Winner strobes non-zero: go to ISSUE.
    - Winner strobes all zero: go to ACK with the internal response set to 2'b00; no bus transfer is made.
  - ISSUE: `BUS_ENA=1` for exactly this cycle; go to WAIT unconditionally.
  - WAIT: `BUS_ENA=0`. On `BUS_DONE=1`, capture `BUS_BRESP` and go to ACK. Otherwise stay, with no timeout.
  - ACK: `REQ_ACK[GRANT_IDX]=1` and `REQ_BRESP` = the captured response; go to IDLE.
- Arbitration: round-robin starting at the pointer.
  - The winner is the first set `REQ_ENA` bit at index pointer, pointer+1, … wrapping modulo `NUM_REQ`.
  - After a grant to index g, the pointer becomes (g+1) mod `NUM_REQ`. This applies to zero-strobe grants too.
- Payload capture: payload is captured only in IDLE. Changes on `REQ_*` after the grant have no effect on the transfer in flight.
- `BUS_DONE` outside WAIT is ignored. This includes `BUS_DONE` in the ISSUE cycle.
- Reset mid-operation: all state clears immediately, with no ack for the in-flight transfer. The write channel is reset by the same `ARESETn`.
- Invalid state encodings: return to IDLE with outputs cleared.

## Timing
- Request acceptance: a request present in IDLE at edge N is granted at edge N; `BUS_ENA` is high in cycle N+1.
- Bus payload: `BUS_ADDR`, `BUS_WDATA` and `BUS_WSTB` are stable from the ISSUE cycle until the next grant.
- Completion: `BUS_DONE` sampled high at edge M puts `REQ_ACK` high in cycle M+1. The next arbitration happens at edge M+2 at the earliest.
- Minimum occupancy: request-to-ack is 4 cycles for a bus transfer (assuming a 1-cycle `BUS_DONE`) and 2 cycles for a zero-strobe request.
- Requester rule: a requester drops `REQ_ENA` at the edge on which it sees `REQ_ACK`, so it is not re-granted. If it keeps `REQ_ENA` high, that is treated as a new request.

## Test plan
- Single write: requester 1 has `ADDR=0x0000_0010`, `WDATA=0xDEAD_BEEF`, `WSTB=0xF`; `BUS_DONE` arrives 3 cycles after `BUS_ENA` with `BRESP=2'b00`.
  - Expect one `BUS_ENA` pulse carrying exactly those values.
  - Expect `REQ_ACK=4'b0010` one cycle after `BUS_DONE`, with `REQ_BRESP=00`.
- Fairness: all four `REQ_ENA` held continuously, each re-asserted after its ack.
  - Expect grant order 0,1,2,3,0,1.
  - Expect exactly one `BUS_ENA` per ack.
- Pointer wrap: grant requester 3, then assert requesters 0 and 2 together.
  - Expect requester 0 next, then requester 2.
- Zero strobe: requester 2 with `WSTB=0x0`.
  - Expect no `BUS_ENA`.
  - Expect `REQ_ACK=4'b0100` 2 cycles after the request, with `REQ_BRESP=00`.
  - Expect the pointer to advance to 3.
- Error and stray done:
  - Pulse `BUS_DONE` in the ISSUE cycle: it must be ignored.
  - A later `BUS_DONE` with `BRESP=2'b10`: expect `REQ_BRESP=10` with the ack.
- Reset mid-WAIT: deassert `ARESETn` while in WAIT.
  - Expect all outputs 0 asynchronously and no `REQ_ACK`.
  - After release, requester 0 has priority.

Source files
------------

// File: rtl/axilm_wr_arb.sv
// -----------------------------------------------------------------------------
// axilm_wr_arb
// Round-robin arbiter that shares one AXI-Lite master write channel between
// NUM_REQ local requesters. One requester is granted at a time. Its address,
// data and strobes are latched and issued to the write channel with a
// single-cycle BUS_ENA. When the channel signals BUS_DONE, the captured
// response is returned with a one-cycle REQ_ACK.
//
// Ports
//   ACLK, ARESETn    clock (rising edge) and asynchronous active-low reset
//   REQ_ENA          per-requester level request, held until REQ_ACK
//   REQ_WSTB/ADDR/   packed per-requester payload (4/32/32 bits each)
//   REQ_WDATA
//   REQ_ACK          one-hot, one-cycle completion pulse
//   REQ_BRESP        response of the acked transfer (held between acks)
//   BUSY             high whenever the FSM is not idle
//   GRANT_IDX        current / last granted requester
//   BUS_ENA          single-cycle write request to the write channel
//   BUS_WSTB/ADDR/   latched payload towards the write channel
//   BUS_WDATA
//   BUS_DONE         write-response captured strobe from the write channel
//   BUS_BRESP        write-channel response, valid with BUS_DONE
// -----------------------------------------------------------------------------
module axilm_wr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [NUM_REQ-1:0]    REQ_ENA,
  input  logic [4*NUM_REQ-1:0]  REQ_WSTB,
  input  logic [32*NUM_REQ-1:0] REQ_ADDR,
  input  logic [32*NUM_REQ-1:0] REQ_WDATA,
  output logic [NUM_REQ-1:0]    REQ_ACK,
  output logic [1:0]            REQ_BRESP,
  output logic                  BUSY,
  output logic [IDX_W-1:0]      GRANT_IDX,
  output logic                  BUS_ENA,
  output logic [3:0]            BUS_WSTB,
  output logic [31:0]           BUS_ADDR,
  output logic [31:0]           BUS_WDATA,
  input  logic                  BUS_DONE,
  input  logic [1:0]            BUS_BRESP
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_ACK   = 2'b11
  } state_t;

  localparam logic [IDX_W:0]   NREQ_L   = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [1:0]           resp_q, resp_d;
  logic [3:0]           bus_wstb_q, bus_wstb_d;
  logic [31:0]          bus_addr_q, bus_addr_d;
  logic [31:0]          bus_wdata_q, bus_wdata_d;
  logic                 bus_ena_q, bus_ena_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic [1:0]           req_bresp_q, req_bresp_d;

  logic                 win_found_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic [IDX_W:0]       cand_s;
  logic [IDX_W:0]       sum_s;

  assign REQ_ACK   = req_ack_q;
  assign REQ_BRESP = req_bresp_q;
  assign BUSY      = busy_q;
  assign GRANT_IDX = grant_q;
  assign BUS_ENA   = bus_ena_q;
  assign BUS_WSTB  = bus_wstb_q;
  assign BUS_ADDR  = bus_addr_q;
  assign BUS_WDATA = bus_wdata_q;

  // Round-robin winner search: scanned from the farthest candidate down to the
  // pointer, so the last hit (closest to the pointer) wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    sum_s       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum_s  = {1'b0, ptr_q} + (IDX_W+1)'(k);
      cand_s = (sum_s >= NREQ_L) ? (sum_s - NREQ_L) : sum_s;
      if (REQ_ENA[cand_s[IDX_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[IDX_W-1:0];
      end else begin
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    resp_d      = resp_q;
    bus_wstb_d  = bus_wstb_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    req_bresp_d = req_bresp_q;
    req_ack_d   = '0;
    bus_ena_d   = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          grant_d     = win_idx_s;
          ptr_d       = (win_idx_s == LAST_IDX) ? '0 : (win_idx_s + ONE_IDX);
          bus_wstb_d  = REQ_WSTB[{win_idx_s, 2'b00} +: 4];
          bus_addr_d  = REQ_ADDR[{win_idx_s, 5'b00000} +: 32];
          bus_wdata_d = REQ_WDATA[{win_idx_s, 5'b00000} +: 32];
          // A request with no strobes enabled is acknowledged without a bus transfer.
          if (REQ_WSTB[{win_idx_s, 2'b00} +: 4] != 4'b0000) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_ACK;
            resp_d  = 2'b00;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (BUS_DONE) begin
          resp_d  = BUS_BRESP;
          state_d = ST_ACK;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        resp_d      = 2'b00;
        bus_wstb_d  = 4'b0000;
        bus_addr_d  = 32'h0000_0000;
        bus_wdata_d = 32'h0000_0000;
        req_bresp_d = 2'b00;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    bus_ena_d = (state_d == ST_ISSUE);
    busy_d    = (state_d != ST_IDLE);
    if (state_d == ST_ACK) begin
      req_ack_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_d;
      req_bresp_d = resp_d;
    end else begin
      req_ack_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      resp_q      <= 2'b00;
      bus_wstb_q  <= 4'b0000;
      bus_addr_q  <= 32'h0000_0000;
      bus_wdata_q <= 32'h0000_0000;
      bus_ena_q   <= 1'b0;
      busy_q      <= 1'b0;
      req_ack_q   <= '0;
      req_bresp_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      resp_q      <= resp_d;
      bus_wstb_q  <= bus_wstb_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_ena_q   <= bus_ena_d;
      busy_q      <= busy_d;
      req_ack_q   <= req_ack_d;
      req_bresp_q <= req_bresp_d;
    end
  end

endmodule

// File: tb/tb_axilm_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_axilm_wr_arb
// Self-checking bench for axilm_wr_arb (NUM_REQ = 4). A table of single
// transactions plus hand-written fairness, stray-done and reset sequences.
// Expected bus payloads and acks are queued when a request is driven and
// popped by a negedge monitor when the DUT produces BUS_ENA / REQ_ACK.
// -----------------------------------------------------------------------------
module tb_axilm_wr_arb;

  localparam int N = 4;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic [N-1:0]  REQ_ENA;
  logic [4*N-1:0]  REQ_WSTB;
  logic [32*N-1:0] REQ_ADDR;
  logic [32*N-1:0] REQ_WDATA;
  logic [N-1:0]  REQ_ACK;
  logic [1:0]    REQ_BRESP;
  logic          BUSY;
  logic [1:0]    GRANT_IDX;
  logic          BUS_ENA;
  logic [3:0]    BUS_WSTB;
  logic [31:0]   BUS_ADDR;
  logic [31:0]   BUS_WDATA;
  logic          BUS_DONE;
  logic [1:0]    BUS_BRESP;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
  } bus_exp_t;

  typedef struct {
    logic [3:0] ack;
    logic [1:0] bresp;
  } ack_exp_t;

  typedef struct {
    logic [3:0]  mask;
    int          win;
    logic [3:0]  exp_ack;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    int          dly;
    logic [1:0]  bresp_in;
    logic [1:0]  exp_bresp;
  } vec_t;

  bus_exp_t bus_q[$];
  ack_exp_t ack_q[$];
  bus_exp_t mon_be;
  ack_exp_t mon_ae;
  vec_t     vecs[7];

  int checks  = 0;
  int errors  = 0;
  int bus_cnt = 0;
  int ack_cnt = 0;

  axilm_wr_arb #(.NUM_REQ(N)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .REQ_ENA   (REQ_ENA),
    .REQ_WSTB  (REQ_WSTB),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .REQ_ACK   (REQ_ACK),
    .REQ_BRESP (REQ_BRESP),
    .BUSY      (BUSY),
    .GRANT_IDX (GRANT_IDX),
    .BUS_ENA   (BUS_ENA),
    .BUS_WSTB  (BUS_WSTB),
    .BUS_ADDR  (BUS_ADDR),
    .BUS_WDATA (BUS_WDATA),
    .BUS_DONE  (BUS_DONE),
    .BUS_BRESP (BUS_BRESP)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ctl"}, {REQ_ACK, REQ_BRESP, BUSY, GRANT_IDX, BUS_ENA, BUS_WSTB}, 64'd0);
    chk({name, "_addr"}, BUS_ADDR, 64'd0);
    chk({name, "_wdata"}, BUS_WDATA, 64'd0);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT emits BUS_ENA or REQ_ACK.
  always @(negedge ACLK) begin
    if (ARESETn === 1'b1) begin
      if (BUS_ENA === 1'b1) begin
        bus_cnt++;
        chk("bus_exp_pending", (bus_q.size() > 0), 64'd1);
        if (bus_q.size() > 0) begin
          mon_be = bus_q.pop_front();
          chk("sb_bus_addr", BUS_ADDR, mon_be.addr);
          chk("sb_bus_wdata", BUS_WDATA, mon_be.wdata);
          chk("sb_bus_wstb", BUS_WSTB, mon_be.wstb);
        end
      end
      if (REQ_ACK !== 4'b0000) begin
        ack_cnt++;
        chk("ack_exp_pending", (ack_q.size() > 0), 64'd1);
        if (ack_q.size() > 0) begin
          mon_ae = ack_q.pop_front();
          chk("sb_req_ack", REQ_ACK, mon_ae.ack);
          chk("sb_req_bresp", REQ_BRESP, mon_ae.bresp);
        end
      end
    end
  end

  // One granted transfer. Called in an idle cycle with REQ_ENA already set;
  // the grant happens at the next edge.
  task automatic run_xact(input int win, input logic [3:0] exp_ack,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstb, input int dly,
                          input logic [1:0] bresp_in, input logic [1:0] exp_bresp,
                          input logic [3:0] clr, input bit stray);
    REQ_ADDR[win*32 +: 32]  = addr;
    REQ_WDATA[win*32 +: 32] = wdata;
    REQ_WSTB[win*4 +: 4]    = wstb;
    if (wstb != 4'h0) bus_q.push_back(bus_exp_t'{addr, wdata, wstb});
    ack_q.push_back(ack_exp_t'{exp_ack, exp_bresp});
    tick();
    chk("grant_idx", GRANT_IDX, win);
    chk("busy_after_grant", BUSY, 64'd1);
    // Scramble the winner's inputs; the latched payload must not follow.
    REQ_ADDR[win*32 +: 32]  = ~addr;
    REQ_WDATA[win*32 +: 32] = ~wdata;
    REQ_WSTB[win*4 +: 4]    = ~wstb;
    if (wstb != 4'h0) begin
      chk("bus_ena_issue", BUS_ENA, 64'd1);
      chk("bus_addr_issue", BUS_ADDR, addr);
      if (stray) begin
        BUS_DONE  = 1'b1;
        BUS_BRESP = 2'b01;
      end
      tick();
      BUS_DONE  = 1'b0;
      BUS_BRESP = 2'b00;
      chk("bus_ena_single", BUS_ENA, 64'd0);
      for (int n = 1; n < dly; n++) begin
        chk("no_early_ack", REQ_ACK, 64'd0);
        tick();
      end
      BUS_DONE  = 1'b1;
      BUS_BRESP = bresp_in;
      tick();
      BUS_DONE  = 1'b0;
      BUS_BRESP = 2'b11;
    end else begin
      chk("zero_stb_no_bus", BUS_ENA, 64'd0);
    end
    chk("req_ack", REQ_ACK, exp_ack);
    chk("req_bresp", REQ_BRESP, exp_bresp);
    chk("bus_wdata_hold", BUS_WDATA, wdata);
    chk("bus_wstb_hold", BUS_WSTB, wstb);
    REQ_ENA = REQ_ENA & ~clr;
    tick();
    chk("ack_one_cycle", REQ_ACK, 64'd0);
    chk("bresp_hold", REQ_BRESP, exp_bresp);
  endtask

  initial begin
    //             mask     win ack      addr          wdata         wstb  dly bresp  exp
    vecs[0] = vec_t'{4'b0010, 1, 4'b0010, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3, 2'b00, 2'b00};
    vecs[1] = vec_t'{4'b0100, 2, 4'b0100, 32'h0000_0020, 32'h1234_5678, 4'h0, 0, 2'b11, 2'b00};
    vecs[2] = vec_t'{4'b0101, 0, 4'b0001, 32'h0000_0100, 32'h1111_2222, 4'h3, 1, 2'b01, 2'b01};
    vecs[3] = vec_t'{4'b0100, 2, 4'b0100, 32'h0000_0204, 32'hA5A5_A5A5, 4'hC, 2, 2'b11, 2'b11};
    vecs[4] = vec_t'{4'b1000, 3, 4'b1000, 32'h0000_030C, 32'h0F0F_0F0F, 4'h1, 1, 2'b00, 2'b00};
    vecs[5] = vec_t'{4'b0101, 0, 4'b0001, 32'h0000_0400, 32'hCAFE_F00D, 4'h8, 4, 2'b10, 2'b10};
    vecs[6] = vec_t'{4'b0100, 2, 4'b0100, 32'h0000_0504, 32'h7777_0000, 4'h0, 0, 2'b01, 2'b00};

    ARESETn   = 1'b0;
    REQ_ENA   = 4'b0000;
    REQ_WSTB  = '0;
    REQ_ADDR  = '0;
    REQ_WDATA = '0;
    BUS_DONE  = 1'b0;
    BUS_BRESP = 2'b00;
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Fairness: all four requests held; grant order 0,1,2,3,0,1.
    REQ_ENA = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      run_xact(k % 4, oh(k % 4), 32'h0000_1000 + 32'(k * 16), 32'h5000_0000 + 32'(k),
               (k % 2 == 0) ? 4'hF : 4'h5, (k % 3) + 1, 2'(k), 2'(k),
               (k == 5) ? 4'b1111 : 4'b0000, 1'b0);
    end
    chk("one_bus_per_ack", bus_cnt, ack_cnt);
    chk("fair_ack_count", ack_cnt, 64'd6);

    // Table-driven single transfers (pointer now at 2).
    for (int i = 0; i < 7; i++) begin
      REQ_ENA = vecs[i].mask;
      run_xact(vecs[i].win, vecs[i].exp_ack, vecs[i].addr, vecs[i].wdata, vecs[i].wstb,
               vecs[i].dly, vecs[i].bresp_in, vecs[i].exp_bresp, vecs[i].exp_ack, 1'b0);
    end

    // Stray BUS_DONE in the ISSUE cycle, then an error response.
    REQ_ENA = 4'b0010;
    run_xact(1, 4'b0010, 32'h0000_0600, 32'h0BAD_F00D, 4'hF, 2, 2'b10, 2'b10, 4'b0010, 1'b1);

    // Reset while waiting for BUS_DONE (pointer at 2 before the grant to 1).
    REQ_ENA = 4'b0010;
    REQ_ADDR[32 +: 32]  = 32'h0000_0700;
    REQ_WDATA[32 +: 32] = 32'h7070_7070;
    REQ_WSTB[4 +: 4]    = 4'hF;
    bus_q.push_back(bus_exp_t'{32'h0000_0700, 32'h7070_7070, 4'hF});
    tick();
    chk("rst_test_grant", GRANT_IDX, 64'd1);
    tick();
    chk("rst_test_wait_busy", BUSY, 64'd1);
    chk("rst_test_wait_no_ena", BUS_ENA, 64'd0);
    #2 ARESETn = 1'b0;
    #1;
    check_all_zero("async_reset");
    REQ_ENA = 4'b0000;
    @(posedge ACLK);
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("no_ack_after_reset", REQ_ACK, 64'd0);
      chk("idle_after_reset", BUSY, 64'd0);
    end
    REQ_ENA = 4'b0101;
    run_xact(0, 4'b0001, 32'h0000_0800, 32'h8888_8888, 4'hF, 1, 2'b00, 2'b00, 4'b0001, 1'b0);
    run_xact(2, 4'b0100, 32'h0000_0900, 32'h9999_9999, 4'h6, 2, 2'b01, 2'b01, 4'b0100, 1'b0);

    repeat (3) tick();
    chk("final_idle", BUSY, 64'd0);
    chk("bus_q_empty", bus_q.size(), 64'd0);
    chk("ack_q_empty", ack_q.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
